// File: rtl/scsi_sd_arbiter.sv
// Round-robin arbiter sharing one host block-device channel between DEVS SCSI targets,
// one sector per grant, with issue timeout and per-transfer word accounting.
module scsi_sd_arbiter #(
  parameter int unsigned DEVS    = 2,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic            clk32,
  input  logic            reset,
  input  logic [31:0]     dev_lba      [DEVS],
  input  logic [DEVS-1:0] dev_rd,
  input  logic [DEVS-1:0] dev_wr,
  output logic [DEVS-1:0] dev_ack,
  input  logic [15:0]     dev_buff_din [DEVS],
  output logic [DEVS-1:0] dev_buff_wr,
  output logic [DEVS-1:0] dev_err,
  output logic [31:0]     sd_lba,
  output logic            sd_rd,
  output logic            sd_wr,
  input  logic            sd_ack,
  input  logic            sd_buff_wr,
  output logic [15:0]     sd_buff_din,
  output logic            busy,
  output logic [8:0]      last_words
);

  localparam int unsigned GW = (DEVS > 1) ? $clog2(DEVS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   g_q, g_d;
  logic [31:0]     lba_q, lba_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [23:0]     tmo_q, tmo_d;
  logic [8:0]      words_q, words_d;
  logic [8:0]      last_q, last_d;
  logic [DEVS-1:0] err_q, err_d;

  logic [DEVS-1:0]   req;
  logic [2*DEVS-1:0] req_dbl;
  logic [DEVS-1:0]   req_rot;
  logic              found;
  logic [GW-1:0]     pick;

  // Rotate requests so bit 0 is rr_q, then take the lowest set bit.
  always_comb begin
    req     = dev_rd | dev_wr;
    req_dbl = {req, req};
    req_rot = DEVS'(req_dbl >> rr_q);
    found   = 1'b0;
    pick    = '0;
    for (int unsigned k = 0; k < DEVS; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pick  = GW'((32'(rr_q) + k) % DEVS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    tmo_d   = tmo_q;
    words_d = words_q;
    last_d  = last_q;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d     = pick;
          lba_d   = dev_lba[pick];
          rd_d    = dev_rd[pick];
          wr_d    = dev_wr[pick] & ~dev_rd[pick];
          tmo_d   = '0;
          words_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else begin
          tmo_d = tmo_q + 24'd1;
          if (tmo_d == TIMEOUT) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            err_d   = DEVS'(1) << g_q;
            state_d = S_RELEASE;
          end
        end
      end
      S_XFER: begin
        if (sd_buff_wr && (words_q != 9'd256)) words_d = words_q + 9'd1;
        if (!sd_ack) begin
          last_d  = words_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        rr_d    = (32'(g_q) == DEVS - 1) ? '0 : g_q + GW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      tmo_q   <= '0;
      words_q <= '0;
      last_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
      words_q <= words_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Host-side ack and strobes only reach the granted device while a command is live.
  always_comb begin
    dev_ack     = '0;
    dev_buff_wr = '0;
    sd_buff_din = '0;
    if ((state_q == S_ISSUE) || (state_q == S_XFER)) dev_ack = DEVS'(sd_ack) << g_q;
    if (state_q == S_XFER) begin
      sd_buff_din = dev_buff_din[g_q];
      dev_buff_wr = DEVS'(sd_buff_wr & sd_ack) << g_q;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign sd_lba     = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign last_words = last_q;
  assign dev_err    = err_q;

endmodule

// File: tb/tb_scsi_sd_arbiter.sv
// Randomised bench for scsi_sd_arbiter against a behavioural model of the
// round-robin grant, sector routing, timeout and word-count rules.
`define CHK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_scsi_sd_arbiter;

  localparam int TMO = 16;

  logic        clk32 = 1'b0;
  logic        reset;
  logic [31:0] dev_lba [2];
  logic [1:0]  dev_rd, dev_wr, dev_ack, dev_buff_wr, dev_err;
  logic [15:0] dev_buff_din [2];
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [15:0] sd_buff_din;
  logic [8:0]  last_words;

  int n_checks = 0;
  int n_fail   = 0;
  int rr       = 0;   // model: device with highest priority next
  int exp_last = 0;   // model: last completed word count

  scsi_sd_arbiter #(.DEVS(2), .TIMEOUT(24'd16)) dut (
    .clk32(clk32), .reset(reset),
    .dev_lba(dev_lba), .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_ack(dev_ack),
    .dev_buff_din(dev_buff_din), .dev_buff_wr(dev_buff_wr), .dev_err(dev_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .busy(busy), .last_words(last_words)
  );

  initial forever #5 clk32 = ~clk32;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic note(input string tag, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  // First requesting device scanning from rr, wrapping around.
  function automatic int pick();
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (rr + k) % 2;
      if (dev_rd[i] || dev_wr[i]) return i;
    end
    return -1;
  endfunction

  function automatic int pick_words();
    case ($urandom_range(0, 5))
      0:       return int'($urandom_range(0, 8));
      1:       return 100;
      2:       return 255;
      3:       return 256;
      4:       return int'($urandom_range(257, 300));
      default: return int'($urandom_range(1, 40));
    endcase
  endfunction

  // Called in an IDLE cycle with requests already driven; returns in the next IDLE cycle.
  task automatic txn(input bit to, input int nwords, input int dly, input bit drop);
    int       g;
    int       sent;
    bit       bw, er, ew;
    logic [15:0] d0, d1;
    g = pick();
    if (g < 0) begin
      `CHK("no_request", 0, 1);
      return;
    end
    er = dev_rd[g];
    ew = dev_wr[g] & ~dev_rd[g];
    dev_buff_din[0] = 16'hA5A5;
    dev_buff_din[1] = 16'h5A5A;
    tick();
    `CHK("grant_lba", sd_lba, dev_lba[g]);
    `CHK("grant_rd", sd_rd, er);
    `CHK("grant_wr", sd_wr, ew);
    `CHK("issue_busy", busy, 1);
    `CHK("issue_din_zero", sd_buff_din, 0);
    `CHK("issue_no_ack", dev_ack, 0);
    if (to) begin
      for (int k = 1; k <= TMO; k++) begin
        tick();
        if (k < TMO) note("to_hold", {sd_rd, sd_wr} === {er, ew});
      end
      `CHK("to_strobes", {sd_rd, sd_wr}, 0);
      `CHK("to_err", dev_err, 1 << g);
      `CHK("to_busy", busy, 1);
      `CHK("to_last", last_words, exp_last);
      tick();
      `CHK("to_err_once", dev_err, 0);
      `CHK("to_idle", busy, 0);
      rr = (g + 1) % 2;
      return;
    end
    for (int k = 0; k < dly; k++) begin
      if (drop && k == 0) begin
        dev_rd[g] = 1'b0;
        dev_wr[g] = 1'b0;
      end
      tick();
      `CHK("issue_hold", {sd_rd, sd_wr}, {er, ew});
    end
    sd_ack = 1'b1;
    #1;
    `CHK("ack_route", dev_ack, 1 << g);
    `CHK("ack_no_bwr", dev_buff_wr, 0);
    tick();
    `CHK("ack_strobe_drop", {sd_rd, sd_wr}, 0);
    dev_rd[g] = 1'b0;
    dev_wr[g] = 1'b0;
    sent = 0;
    while (sent < nwords) begin
      bw = ($urandom_range(0, 3) != 0);
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      dev_buff_din[0] = d0;
      dev_buff_din[1] = d1;
      sd_buff_wr = bw;
      #1;
      note("bwr_route", dev_buff_wr === (bw ? 2'(1 << g) : 2'b00));
      note("xfer_din", sd_buff_din === ((g == 0) ? d0 : d1));
      note("xfer_ack", dev_ack === 2'(1 << g));
      if (bw) sent++;
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    exp_last = (sent > 256) ? 256 : sent;
    `CHK("last_words", last_words, exp_last);
    `CHK("rel_busy", busy, 1);
    `CHK("rel_din_zero", sd_buff_din, 0);
    `CHK("rel_no_err", dev_err, 0);
    sd_ack = 1'b1;
    sd_buff_wr = 1'b1;
    #1;
    `CHK("rel_spurious_ack", dev_ack, 0);
    `CHK("rel_spurious_bwr", dev_buff_wr, 0);
    tick();
    `CHK("idle_busy", busy, 0);
    `CHK("idle_spurious_ack", dev_ack, 0);
    `CHK("idle_spurious_bwr", dev_buff_wr, 0);
    `CHK("idle_strobes", {sd_rd, sd_wr}, 0);
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    rr = (g + 1) % 2;
  endtask

  initial begin
    int kind;
    reset = 1'b1;
    dev_rd = '0; dev_wr = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    dev_lba[0] = 32'h0; dev_lba[1] = 32'h0;
    dev_buff_din[0] = 16'h1111; dev_buff_din[1] = 16'h2222;
    tick(); tick();
    `CHK("rst_sd_rd", sd_rd, 0);
    `CHK("rst_sd_wr", sd_wr, 0);
    `CHK("rst_sd_lba", sd_lba, 0);
    `CHK("rst_last", last_words, 0);
    `CHK("rst_err", dev_err, 0);
    `CHK("rst_ack", dev_ack, 0);
    `CHK("rst_bwr", dev_buff_wr, 0);
    `CHK("rst_din", sd_buff_din, 0);
    `CHK("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Round-robin with both devices requesting, then only device 1.
    dev_lba[0] = 32'hAAAA_0000; dev_lba[1] = 32'hBBBB_1111;
    for (int i = 0; i < 3; i++) begin
      dev_rd = 2'b11;
      txn(1'b0, 4, 1, 1'b0);
    end
    dev_rd[0] = 1'b0;
    dev_rd[1] = 1'b1;
    txn(1'b0, 3, 0, 1'b0);

    // Single full-sector read on device 0.
    dev_lba[0] = 32'h1234;
    dev_rd = 2'b01;
    txn(1'b0, 256, 1, 1'b0);

    // Write on device 1.
    dev_lba[1] = 32'h0000_BEEF;
    dev_wr = 2'b10;
    txn(1'b0, 20, 2, 1'b0);

    // Timeout on device 0; the held request is then served normally.
    dev_rd = 2'b01;
    txn(1'b1, 0, 0, 1'b0);
    txn(1'b0, 5, 0, 1'b1);

    // Read and write together on device 0: read wins.
    dev_rd = 2'b01; dev_wr = 2'b01;
    txn(1'b0, 2, 1, 1'b0);

    // Random traffic.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(dev_rd[i] || dev_wr[i]) && ($urandom_range(0, 1) == 1)) begin
          kind = int'($urandom_range(1, 3));
          dev_rd[i] = kind[0];
          dev_wr[i] = kind[1];
          dev_lba[i] = $urandom;
        end
      end
      if (pick() < 0) begin
        kind = int'($urandom_range(0, 1));
        dev_rd[kind] = 1'b1;
        dev_lba[kind] = $urandom;
      end
      txn($urandom_range(0, 7) == 0, pick_words(), int'($urandom_range(0, 4)),
          $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of a sector.
    dev_rd = 2'b10; dev_wr = 2'b00;
    dev_lba[1] = 32'hCAFE_0001;
    tick();
    sd_ack = 1'b1;
    tick();
    dev_rd = 2'b00;
    sd_buff_wr = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    `CHK("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    `CHK("mid_rst_sd_rd", sd_rd, 0);
    `CHK("mid_rst_lba", sd_lba, 0);
    `CHK("mid_rst_ack", dev_ack, 0);
    `CHK("mid_rst_bwr", dev_buff_wr, 0);
    `CHK("mid_rst_din", sd_buff_din, 0);
    `CHK("mid_rst_busy", busy, 0);
    `CHK("mid_rst_last", last_words, 0);
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    rr = 0;
    exp_last = 0;
    `CHK("post_rst_last", last_words, 0);
    dev_lba[0] = 32'h0000_00F0; dev_lba[1] = 32'h0000_00F1;
    dev_rd = 2'b11;
    txn(1'b0, 7, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
